// File: rtl/cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// cpu_trace_buffer
//
// Instruction-trace capture unit for the multicycle LEGv8 computer. On every
// instruction-fetch cycle (sample_en) while capture is running, the current
// PC, IR and control word are written into a circular buffer. A PC-match
// trigger starts a post-trigger countdown; when it expires the buffer freezes.
// The frozen buffer is then read out oldest-first over a request/valid port.
//
// Optional feature (macro CPU_TRACE_TIMESTAMP_EN):
//   When defined, a free-running TS_WIDTH cycle counter is stored with each
//   entry and returned on rd_ts. When undefined, no counter or timestamp
//   storage exists and rd_ts is 0.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   arm          in   one-cycle pulse: clear buffer, start capture
//   sample_en    in   record pc/ir/control_word this cycle
//   pc           in   current PC                      [PC_WIDTH]
//   ir           in   current IR                      [IR_WIDTH]
//   control_word in   current control word            [CW_WIDTH]
//   trig_pc      in   trigger PC value                [PC_WIDTH]
//   trig_en      in   enables the PC-match trigger
//   armed        out  capture in progress (ARMED or POST)
//   triggered    out  trigger seen since the last arm
//   done         out  capture frozen, readout allowed
//   rd_req       in   request next entry
//   rd_valid     out  rd_* outputs valid this cycle
//   rd_pc        out  entry PC                        [PC_WIDTH]
//   rd_ir        out  entry IR                        [IR_WIDTH]
//   rd_cw        out  entry control word              [CW_WIDTH]
//   rd_ts        out  entry timestamp                 [TS_WIDTH]
//   rd_last      out  with rd_valid on the final entry
//   count        out  valid entries, saturating at DEPTH [$clog2(DEPTH)+1]
// -----------------------------------------------------------------------------
module cpu_trace_buffer #(
  parameter int CW_WIDTH  = 36,
  parameter int PC_WIDTH  = 32,
  parameter int IR_WIDTH  = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int TS_WIDTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     sample_en,
  input  logic [PC_WIDTH-1:0]      pc,
  input  logic [IR_WIDTH-1:0]      ir,
  input  logic [CW_WIDTH-1:0]      control_word,
  input  logic [PC_WIDTH-1:0]      trig_pc,
  input  logic                     trig_en,
  output logic                     armed,
  output logic                     triggered,
  output logic                     done,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [PC_WIDTH-1:0]      rd_pc,
  output logic [IR_WIDTH-1:0]      rd_ir,
  output logic [CW_WIDTH-1:0]      rd_cw,
  output logic [TS_WIDTH-1:0]      rd_ts,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] POST_C  = PTR_W'(POST_TRIG);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;     // entries already read out
  logic [PTR_W-1:0]      post_cnt_q, post_cnt_d;
  logic                  triggered_q, triggered_d;
  logic                  armed_q, armed_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [PC_WIDTH-1:0]   rd_pc_q, rd_pc_d;
  logic [IR_WIDTH-1:0]   rd_ir_q, rd_ir_d;
  logic [CW_WIDTH-1:0]   rd_cw_q, rd_cw_d;
  logic [TS_WIDTH-1:0]   rd_ts_q, rd_ts_d;
  logic [TS_WIDTH-1:0]   rd_ts_sel;
  logic                  wr_en;
  logic                  trig_hit;

  logic [PC_WIDTH-1:0]   mem_pc_q [DEPTH];
  logic [IR_WIDTH-1:0]   mem_ir_q [DEPTH];
  logic [CW_WIDTH-1:0]   mem_cw_q [DEPTH];

`ifdef CPU_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [TS_WIDTH-1:0]   mem_ts_q [DEPTH];

  // Free-running timestamp increment.
  always_comb begin
    ts_d = ts_q + TS_WIDTH'(1);
  end

  // Timestamp counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  // Timestamp storage, written alongside each trace entry.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_ts_q[wr_ptr_q] <= ts_q;
    end
  end

  assign rd_ts_sel = mem_ts_q[rd_ptr_q];
`else
  assign rd_ts_sel = '0;
`endif

  // Trace storage; contents are hidden by count after reset, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_pc_q[wr_ptr_q] <= pc;
      mem_ir_q[wr_ptr_q] <= ir;
      mem_cw_q[wr_ptr_q] <= control_word;
    end
  end

  // Next-state, capture and readout logic.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_cnt_d    = rd_cnt_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    rd_pc_d     = rd_pc_q;
    rd_ir_d     = rd_ir_q;
    rd_cw_d     = rd_cw_q;
    rd_ts_d     = rd_ts_q;
    wr_en       = 1'b0;
    trig_hit    = sample_en && trig_en && (pc == trig_pc);

    if (arm) begin
      // arm wins over everything, including a same-cycle sample or read
      state_d     = ST_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_cnt_d    = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ARMED, ST_POST: begin
          if (sample_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = (count_q == DEPTH_C) ? count_q : count_q + CNT_W'(1);
            if (state_q == ST_ARMED) begin
              if (trig_hit) begin
                triggered_d = 1'b1;
                if (POST_TRIG == 0) begin
                  state_d = ST_DONE;
                end else begin
                  state_d    = ST_POST;
                  post_cnt_d = POST_C;
                end
              end else begin
                state_d = ST_ARMED;
              end
            end else begin
              // POST: trigger matches are ignored, only the countdown matters
              post_cnt_d = post_cnt_q - PTR_W'(1);
              if (post_cnt_q == PTR_W'(1)) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_POST;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: begin
          if (rd_req && (rd_cnt_q < count_q)) begin
            rd_valid_d = 1'b1;
            rd_last_d  = ((rd_cnt_q + CNT_W'(1)) == count_q);
            rd_pc_d    = mem_pc_q[rd_ptr_q];
            rd_ir_d    = mem_ir_q[rd_ptr_q];
            rd_cw_d    = mem_cw_q[rd_ptr_q];
            rd_ts_d    = rd_ts_sel;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          end else begin
            rd_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // On freeze, point at the oldest entry: after a wrap that is the slot
    // the next write would have used.
    if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
      rd_ptr_d = (count_d == DEPTH_C) ? wr_ptr_d : '0;
    end else begin
      rd_ptr_d = rd_ptr_d;
    end

    armed_d = (state_d == ST_ARMED) || (state_d == ST_POST);
    done_d  = (state_d == ST_DONE);
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_cnt_q    <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_pc_q     <= '0;
      rd_ir_q     <= '0;
      rd_cw_q     <= '0;
      rd_ts_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_cnt_q    <= rd_cnt_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_pc_q     <= rd_pc_d;
      rd_ir_q     <= rd_ir_d;
      rd_cw_q     <= rd_cw_d;
      rd_ts_q     <= rd_ts_d;
    end
  end

  assign armed     = armed_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_pc     = rd_pc_q;
  assign rd_ir     = rd_ir_q;
  assign rd_cw     = rd_cw_q;
  assign rd_ts     = rd_ts_q;
  assign count     = count_q;

endmodule
